// File: rtl/doom58_pkg.sv
// doom58_pkg: shared screen geometry, colour types and packing helpers for
// the raycaster display path.
//   SCREEN_W / SCREEN_H   : visible columns / rows drawn per column
//   CEIL_COLOUR / FLOOR_COLOUR : fixed backdrop colours, {R,G,B} 6b each
//   colour_t / chan_t     : packed 18b pixel colour and a 6b channel
//   col_req_t             : a column request as latched by column_plotter
package doom58_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef logic [17:0] colour_t;
    typedef logic [5:0]  chan_t;

    typedef struct packed {
        chan_t r;
        chan_t g;
        chan_t b;
    } rgb_t;

    localparam colour_t CEIL_COLOUR  = 18'h00FFF;
    localparam colour_t FLOOR_COLOUR = 18'h15555;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } plot_state_t;

    // Everything the draw phase needs, captured on the accept edge.
    typedef struct packed {
        logic [7:0] x;
        logic [6:0] top;
        logic [6:0] bot;
        colour_t    wall;
        logic       on;     // column is on-screen, pixels are written
    } col_req_t;

    function automatic colour_t pack_rgb(input chan_t r, input chan_t g, input chan_t b);
        return {r, g, b};
    endfunction

    function automatic rgb_t unpack_rgb(input colour_t c);
        return rgb_t'(c);
    endfunction

endpackage

// File: rtl/wall_span_calc.sv
// wall_span_calc: combinational wall span for one column.
//   height : requested wall height in pixels (0..127)
//   top    : first wall row, (SCREEN_H - min(height, SCREEN_H)) >> 1
//   bot    : first floor row below the wall, top + clamped height
module wall_span_calc
    import doom58_pkg::*;
(
    input  logic [6:0] height,
    output logic [6:0] top,
    output logic [6:0] bot
);

    localparam logic [6:0] ROWS = 7'(SCREEN_H);

    logic [6:0] h_clamp;

    assign h_clamp = (height > ROWS) ? ROWS : height;
    assign top     = (ROWS - h_clamp) >> 1;
    // top + h_clamp never exceeds SCREEN_H, so 7 bits hold it.
    assign bot     = top + h_clamp;

endmodule

// File: rtl/column_plotter.sv
// column_plotter: turns one column request into SCREEN_H serial pixel
// writes (ceiling, wall, floor), one per clock, straight into vga_adapter.
//   clock, reset          : system clock, synchronous active-high reset
//   col_valid/col_ready   : request handshake, ready only while IDLE
//   col_x/height/colour   : target column, wall height, wall colour
//   col_shade             : wall darkening, 0..3 (COLUMN_SHADE_EN builds)
//   col_done              : pulse with the last pixel (or alone, off-screen)
//   vga_x/y/colour/write  : registered pixel write to the adapter
// Build option: define COLUMN_SHADE_EN to shift each wall channel right by
// col_shade; otherwise col_shade is ignored.
module column_plotter
    import doom58_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        col_valid,
    output logic        col_ready,
    input  logic [7:0]  col_x,
    input  logic [6:0]  col_height,
    input  logic [17:0] col_colour,
    input  logic [1:0]  col_shade,
    output logic        col_done,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [17:0] vga_colour,
    output logic        vga_write
);

    localparam logic [6:0] LAST_ROW = 7'(SCREEN_H - 1);

    plot_state_t state, state_nxt;
    col_req_t    req_q, req_nxt;

    logic [6:0]  span_top, span_bot;
    colour_t     wall_in;
    logic        on_in;
    logic [6:0]  y_inc;

    logic [7:0]  x_nxt;
    logic [6:0]  y_nxt;
    colour_t     colour_nxt;
    logic        write_nxt;
    logic        done_nxt;

    wall_span_calc u_span (
        .height (col_height),
        .top    (span_top),
        .bot    (span_bot)
    );

`ifdef COLUMN_SHADE_EN
    rgb_t wall_rgb;
    assign wall_rgb = unpack_rgb(col_colour);
    assign wall_in  = pack_rgb(wall_rgb.r >> col_shade,
                               wall_rgb.g >> col_shade,
                               wall_rgb.b >> col_shade);
`else
    // Shade has no effect here; the term only keeps the port referenced.
    assign wall_in = col_colour | {18{1'b0 & (^col_shade)}};
`endif

    assign on_in     = (col_x < 8'(SCREEN_W));
    assign y_inc     = vga_y + 7'd1;
    assign col_ready = (state == IDLE);

    function automatic colour_t row_colour(input logic [6:0] y, input logic [6:0] top,
                                           input logic [6:0] bot, input colour_t wall);
        if (y < top)
            return CEIL_COLOUR;
        else if (y < bot)
            return wall;
        else
            return FLOOR_COLOUR;
    endfunction

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Row 0 is issued on the accept edge itself, so DRAW lasts exactly as
    // long as writes are on the bus (one cycle for an off-screen column).
    always_comb begin
        state_nxt  = state;
        req_nxt    = req_q;
        x_nxt      = vga_x;
        y_nxt      = vga_y;
        colour_nxt = vga_colour;
        write_nxt  = 1'b0;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (col_valid) begin
                    state_nxt    = DRAW;
                    req_nxt.x    = col_x;
                    req_nxt.top  = span_top;
                    req_nxt.bot  = span_bot;
                    req_nxt.wall = wall_in;
                    req_nxt.on   = on_in;
                    if (on_in) begin
                        write_nxt  = 1'b1;
                        x_nxt      = col_x;
                        y_nxt      = 7'd0;
                        colour_nxt = row_colour(7'd0, span_top, span_bot, wall_in);
                    end else begin
                        done_nxt   = 1'b1;
                    end
                end
            end
            DRAW: begin
                if (req_q.on && (vga_y != LAST_ROW)) begin
                    write_nxt  = 1'b1;
                    y_nxt      = y_inc;
                    colour_nxt = row_colour(y_inc, req_q.top, req_q.bot, req_q.wall);
                    done_nxt   = (y_inc == LAST_ROW);
                end else begin
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            req_q      <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_write  <= 1'b0;
            col_done   <= 1'b0;
        end else begin
            req_q      <= req_nxt;
            vga_x      <= x_nxt;
            vga_y      <= y_nxt;
            vga_colour <= colour_nxt;
            vga_write  <= write_nxt;
            col_done   <= done_nxt;
        end
    end

endmodule

// File: tb/tb_column_plotter.sv
// tb_column_plotter: randomized and directed column requests checked against
// a per-row arithmetic model of the ceiling/wall/floor split.
module tb_column_plotter;

    logic        clock = 1'b0;
    logic        reset;
    logic        col_valid;
    logic        col_ready;
    logic [7:0]  col_x;
    logic [6:0]  col_height;
    logic [17:0] col_colour;
    logic [1:0]  col_shade;
    logic        col_done;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [17:0] vga_colour;
    logic        vga_write;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    column_plotter dut (
        .clock      (clock),
        .reset      (reset),
        .col_valid  (col_valid),
        .col_ready  (col_ready),
        .col_x      (col_x),
        .col_height (col_height),
        .col_colour (col_colour),
        .col_shade  (col_shade),
        .col_done   (col_done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_write  (vga_write)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected colour of row y for a request, straight from the span rules.
    function automatic logic [17:0] exp_pixel(input int y, input int h,
                                              input logic [17:0] c, input int s);
        int hh, top, bot;
        logic [17:0] wall;
        hh  = (h > 120) ? 120 : h;
        top = (120 - hh) / 2;
        bot = top + hh;
`ifdef COLUMN_SHADE_EN
        wall = {c[17:12] >> s, c[11:6] >> s, c[5:0] >> s};
`else
        wall = c;
`endif
        if (y < top)      return 18'h00FFF;
        else if (y < bot) return wall;
        else              return 18'h15555;
    endfunction

    // Issue one request and check every cycle of its response.
    // hold: leave col_valid high afterwards; abort_at: assert reset while row
    // abort_at is on the bus (-1 for none); acc_cyc: cycle of the accept edge.
    task automatic run_col(input int x, input int h, input logic [17:0] c, input int s,
                           input bit hold, input int abort_at, output int acc_cyc);
        int waited;
        acc_cyc = 0;
        @(negedge clock);
        col_x      = 8'(x);
        col_height = 7'(h);
        col_colour = c;
        col_shade  = 2'(s);
        col_valid  = 1'b1;
        waited = 0;
        while (!col_ready && waited < 300) begin
            @(negedge clock);
            waited++;
        end
        if (!col_ready) begin
            chk("ready_timeout", 32'(col_ready), 32'd1);
            col_valid = 1'b0;
            return;
        end
        @(posedge clock); #1;
        acc_cyc = cyc;
        if (!hold) begin
            // Changes after the accept edge must not disturb the column.
            col_valid  = 1'b0;
            col_x      = 8'($urandom);
            col_height = 7'($urandom);
            col_colour = 18'($urandom);
            col_shade  = 2'($urandom);
        end
        if (x >= 160) begin
            chk("off_write", 32'(vga_write), 32'd0);
            chk("off_done",  32'(col_done),  32'd1);
            chk("off_ready", 32'(col_ready), 32'd0);
            @(posedge clock); #1;
            chk("off_write2", 32'(vga_write), 32'd0);
            chk("off_done2",  32'(col_done),  32'd0);
            chk("off_ready2", 32'(col_ready), 32'd1);
            return;
        end
        for (int k = 0; k < 120; k++) begin
            if (k == abort_at) begin
                reset = 1'b1;
                @(posedge clock); #1;
                chk("abort_write",  32'(vga_write),  32'd0);
                chk("abort_ready",  32'(col_ready),  32'd1);
                chk("abort_done",   32'(col_done),   32'd0);
                chk("abort_x",      32'(vga_x),      32'd0);
                chk("abort_y",      32'(vga_y),      32'd0);
                chk("abort_colour", 32'(vga_colour), 32'd0);
                reset = 1'b0;
                return;
            end
            chk("write",  32'(vga_write),  32'd1);
            chk("x",      32'(vga_x),      32'(x));
            chk("y",      32'(vga_y),      32'(k));
            chk("colour", 32'(vga_colour), 32'(exp_pixel(k, h, c, s)));
            chk("done",   32'(col_done),   32'(k == 119));
            chk("busy",   32'(col_ready),  32'd0);
            @(posedge clock); #1;
        end
        chk("end_write", 32'(vga_write), 32'd0);
        chk("end_done",  32'(col_done),  32'd0);
        chk("end_ready", 32'(col_ready), 32'd1);
        chk("end_hold_y", 32'(vga_y),    32'd119);
    endtask

    initial begin
        int a0, a1, a2;
        reset      = 1'b1;
        col_valid  = 1'b0;
        col_x      = '0;
        col_height = '0;
        col_colour = '0;
        col_shade  = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ready",  32'(col_ready),  32'd1);
        chk("rst_write",  32'(vga_write),  32'd0);
        chk("rst_done",   32'(col_done),   32'd0);
        chk("rst_x",      32'(vga_x),      32'd0);
        chk("rst_y",      32'(vga_y),      32'd0);
        chk("rst_colour", 32'(vga_colour), 32'd0);
        reset = 1'b0;

        run_col(10, 40, 18'h3F000, 0, 1'b0, -1, a0);
        run_col(11, 0, 18'h2A2A2, 1, 1'b0, -1, a0);
        run_col(12, 127, 18'h01234, 3, 1'b0, -1, a0);
        run_col(13, 41, 18'h3FFFF, 0, 1'b0, -1, a0);
        run_col(159, 120, 18'h12345, 0, 1'b0, -1, a0);
        run_col(200, 50, 18'h3F000, 0, 1'b0, -1, a0);
        run_col(160, 10, 18'h00001, 0, 1'b0, -1, a0);

        // Back-to-back with col_valid never dropping.
        run_col(20, 60, 18'h0F0F0, 0, 1'b1, -1, a0);
        run_col(21, 30, 18'h30303, 0, 1'b1, -1, a1);
        run_col(22, 90, 18'h03030, 0, 1'b1, -1, a2);
        col_valid = 1'b0;
        chk("hold_gap1", 32'(a1 - a0), 32'd121);
        chk("hold_gap2", 32'(a2 - a1), 32'd121);

        run_col(30, 40, 18'h3F000, 0, 1'b0, 50, a0);
        run_col(31, 40, 18'h3F000, 0, 1'b0, -1, a0);

        run_col(5, 40, 18'h3FFFF, 2, 1'b0, -1, a0);

        for (int i = 0; i < 20; i++)
            run_col(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                    18'($urandom), int'($urandom_range(0, 3)), 1'b0, -1, a0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
